// File: rtl/mdio_pkg.sv
// Shared definitions for the MDIO (clause 22) management responder:
// FSM encoding, frame constants and field widths.
package mdio_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_OP,
    S_PHYAD,
    S_REGAD,
    S_TA,
    S_WDATA,
    S_RDATA
  } state_t;

  localparam logic [1:0] ST    = 2'b01;
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_RD = 2'b10;

  localparam int PHYAD_W = 5;
  localparam int REGAD_W = 5;
  localparam int DATA_W  = 16;

endpackage

// File: rtl/mdio_sync.sv
// Brings mdc and mdio into the clk domain through 2-flop synchronizers and
// flags each rising edge of the synchronized mdc as a single-clk bit event.
module mdio_sync (
  input  logic clk,
  input  logic reset,
  input  logic mdc_i,
  input  logic mdio_i,
  output logic mdc_rise_o,
  output logic mdio_o
);

  // mdc_q[2] is edge-detect history behind the two synchronizer stages.
  logic [2:0] mdc_q;
  logic [1:0] mdio_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mdc_q  <= '0;
      mdio_q <= '0;
    end else begin
      mdc_q  <= {mdc_q[1:0], mdc_i};
      mdio_q <= {mdio_q[0], mdio_i};
    end
  end

  assign mdc_rise_o = mdc_q[1] & ~mdc_q[2];
  assign mdio_o     = mdio_q[1];

endmodule

// File: rtl/mdio_responder.sv
// MDIO responder: decodes clause-22 frames addressed to PHY_ADDR, issues
// register read/write strobes and serializes read data back onto the line.
module mdio_responder
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR = 5'd1,
  parameter int         PRE_MIN  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdc,
  input  logic        mdio_in,
  output logic        mdio_out,
  output logic        mdio_oe,
  output logic [4:0]  addr,
  output logic [15:0] wr_data,
  output logic        wr_stb,
  output logic        rd_stb,
  input  logic [15:0] rd_data,
  output logic        frame_err
);

  localparam int               PRE_W   = $clog2(PRE_MIN + 1);
  localparam logic [PRE_W-1:0] PRE_SAT = PRE_W'(PRE_MIN);

  logic bit_ev;
  logic bit_in;

  mdio_sync u_sync (
    .clk        (clk),
    .reset      (reset),
    .mdc_i      (mdc),
    .mdio_i     (mdio_in),
    .mdc_rise_o (bit_ev),
    .mdio_o     (bit_in)
  );

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [14:0]      rx_q, rx_d;
  logic [15:0]      tx_q, tx_d;
  logic             is_rd_q, is_rd_d;
  logic [4:0]       addr_q, addr_d;
  logic [15:0]      wr_data_q, wr_data_d;
  logic             wr_stb_q, wr_stb_d;
  logic             rd_stb_q, rd_stb_d;
  logic             rd_cap_q, rd_cap_d;
  logic             err_q, err_d;
  logic             oe_q, oe_d;
  logic             out_q, out_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pre_q     <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      is_rd_q   <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
      wr_stb_q  <= 1'b0;
      rd_stb_q  <= 1'b0;
      rd_cap_q  <= 1'b0;
      err_q     <= 1'b0;
      oe_q      <= 1'b0;
      out_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pre_q     <= pre_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      is_rd_q   <= is_rd_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      wr_stb_q  <= wr_stb_d;
      rd_stb_q  <= rd_stb_d;
      rd_cap_q  <= rd_cap_d;
      err_q     <= err_d;
      oe_q      <= oe_d;
      out_q     <= out_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pre_d     = pre_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    is_rd_d   = is_rd_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    wr_stb_d  = 1'b0;
    rd_stb_d  = 1'b0;
    rd_cap_d  = rd_stb_q;
    err_d     = 1'b0;
    oe_d      = oe_q;
    out_d     = out_q;

    // The register file answers one clk after rd_stb; mdc is far slower,
    // so this capture always lands well before the first TA bit event.
    if (rd_cap_q) begin
      tx_d = rd_data;
    end

    if (bit_ev) begin
      rx_d  = {rx_q[13:0], bit_in};
      cnt_d = cnt_q + 4'd1;
      unique case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (bit_in) begin
            if (pre_q < PRE_SAT) pre_d = pre_q + PRE_W'(1);
          end else begin
            if (pre_q >= PRE_SAT) state_d = S_START;
            pre_d = '0;
          end
        end
        S_START: begin
          cnt_d = '0;
          if (bit_in == ST[0]) begin
            state_d = S_OP;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_OP: begin
          if (cnt_q == 4'd1) begin
            cnt_d = '0;
            if ({rx_q[0], bit_in} == OP_WR) begin
              is_rd_d = 1'b0;
              state_d = S_PHYAD;
            end else if ({rx_q[0], bit_in} == OP_RD) begin
              is_rd_d = 1'b1;
              state_d = S_PHYAD;
            end else begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
        S_PHYAD: begin
          if (cnt_q == 4'(PHYAD_W - 1)) begin
            cnt_d   = '0;
            state_d = ({rx_q[3:0], bit_in} == PHY_ADDR) ? S_REGAD : S_IDLE;
          end
        end
        S_REGAD: begin
          addr_d = {addr_q[3:0], bit_in};
          if (cnt_q == 4'(REGAD_W - 1)) begin
            cnt_d    = '0;
            rd_stb_d = is_rd_q;
            state_d  = S_TA;
          end
        end
        S_TA: begin
          if (cnt_q == 4'd0) begin
            // Initiator releases the line during TA bit 1; we take it for bit 2.
            if (is_rd_q) begin
              oe_d  = 1'b1;
              out_d = 1'b0;
            end
          end else begin
            cnt_d = '0;
            if (is_rd_q) begin
              out_d   = tx_q[15];
              tx_d    = {tx_q[14:0], 1'b0};
              state_d = S_RDATA;
            end else begin
              state_d = S_WDATA;
            end
          end
        end
        S_WDATA: begin
          if (cnt_q == 4'(DATA_W - 1)) begin
            cnt_d     = '0;
            wr_data_d = {rx_q, bit_in};
            wr_stb_d  = 1'b1;
            state_d   = S_IDLE;
          end
        end
        S_RDATA: begin
          if (cnt_q == 4'(DATA_W - 1)) begin
            cnt_d   = '0;
            oe_d    = 1'b0;
            out_d   = 1'b0;
            state_d = S_IDLE;
          end else begin
            out_d = tx_q[15];
            tx_d  = {tx_q[14:0], 1'b0};
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign mdio_out  = out_q;
  assign mdio_oe   = oe_q;
  assign addr      = addr_q;
  assign wr_data   = wr_data_q;
  assign wr_stb    = wr_stb_q;
  assign rd_stb    = rd_stb_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_mdio_responder.sv
// Directed bench for mdio_responder: drives MDIO frames bit by bit and checks
// strobes, captured fields and the serialized read data on the line.
module tb_mdio_responder;

  logic        clk;
  logic        reset;
  logic        mdc;
  logic        mdio_in;
  logic        mdio_out;
  logic        mdio_oe;
  logic [4:0]  addr;
  logic [15:0] wr_data;
  logic        wr_stb;
  logic        rd_stb;
  logic [15:0] rd_data;
  logic        frame_err;

  int checks = 0;
  int errors = 0;

  int wr_cnt = 0;
  int rd_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  logic oe_seen = 1'b0;

  logic [15:0] mem [0:31];

  mdio_responder #(.PHY_ADDR(5'd1), .PRE_MIN(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .mdc       (mdc),
    .mdio_in   (mdio_in),
    .mdio_out  (mdio_out),
    .mdio_oe   (mdio_oe),
    .addr      (addr),
    .wr_data   (wr_data),
    .wr_stb    (wr_stb),
    .rd_stb    (rd_stb),
    .rd_data   (rd_data),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event monitors and a small register file behind the strobes.
  always @(posedge clk) begin
    if (wr_stb) wr_cnt++;
    if (rd_stb) rd_cnt++;
    if (frame_err) err_cnt++;
    if (wr_stb && rd_stb) both_cnt++;
    if (mdio_oe) oe_seen = 1'b1;
    if (wr_stb) mem[addr] = wr_data;
  end

  always @(posedge clk) begin
    if (rd_stb) rd_data <= mem[addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mbit(input logic b);
    mdio_in = b;
    #40 mdc = 1'b1;
    #40 mdc = 1'b0;
  endtask

  task automatic preamble(input int n);
    for (int i = 0; i < n; i++) mbit(1'b1);
  endtask

  task automatic header(input logic [1:0] op, input logic [4:0] pa, input logic [4:0] ra);
    mbit(1'b0);
    mbit(1'b1);
    for (int i = 1; i >= 0; i--) mbit(op[i]);
    for (int i = 4; i >= 0; i--) mbit(pa[i]);
    for (int i = 4; i >= 0; i--) mbit(ra[i]);
  endtask

  task automatic write_frame(input int pre, input logic [4:0] pa, input logic [4:0] ra,
                             input logic [15:0] d);
    preamble(pre);
    header(2'b01, pa, ra);
    mbit(1'b1);
    mbit(1'b0);
    for (int i = 15; i >= 0; i--) mbit(d[i]);
    mdio_in = 1'b1;
    #200;
  endtask

  // Samples the line at the end of each mdc low phase, as an initiator would.
  task automatic read_frame(input logic [4:0] ra, input int nbits,
                            output logic ta1_oe, output logic ta2_oe, output logic ta2_out,
                            output int oe_low, output logic [15:0] got);
    preamble(32);
    header(2'b10, 5'd1, ra);
    mdio_in = 1'b1;
    #40 ta1_oe = mdio_oe;
    mdc = 1'b1;
    #40 mdc = 1'b0;
    #40 ta2_oe = mdio_oe;
    ta2_out = mdio_out;
    mdc = 1'b1;
    #40 mdc = 1'b0;
    got = '0;
    oe_low = 0;
    for (int i = 0; i < nbits; i++) begin
      #40;
      if (!mdio_oe) oe_low++;
      got = {got[14:0], mdio_out};
      mdc = 1'b1;
      #40 mdc = 1'b0;
    end
  endtask

  initial begin
    logic ta1_oe, ta2_oe, ta2_out;
    int oe_low;
    logic [15:0] got;
    int wr0, rd0, er0;

    for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
    reset   = 1'b0;
    mdc     = 1'b0;
    mdio_in = 1'b1;

    // Reset state
    #22;
    check("rst_oe", 32'(mdio_oe), 32'd0);
    check("rst_out", 32'(mdio_out), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_strobes", 32'({wr_stb, rd_stb, frame_err}), 32'd0);
    #18 reset = 1'b1;
    #100;

    // Basic write
    oe_seen = 1'b0;
    wr0 = wr_cnt; rd0 = rd_cnt; er0 = err_cnt;
    write_frame(32, 5'd1, 5'h05, 16'hBEEF);
    check("wr_count", 32'(wr_cnt - wr0), 32'd1);
    check("wr_addr", 32'(addr), 32'h05);
    check("wr_data", 32'(wr_data), 32'hBEEF);
    check("wr_no_oe", 32'(oe_seen), 32'd0);
    check("wr_no_rd_err", 32'((rd_cnt - rd0) + (err_cnt - er0)), 32'd0);

    // Basic read
    mem[31] = 16'hA5C3;
    wr0 = wr_cnt; rd0 = rd_cnt; er0 = err_cnt;
    read_frame(5'h1F, 16, ta1_oe, ta2_oe, ta2_out, oe_low, got);
    #100;
    check("rd_ta1_z", 32'(ta1_oe), 32'd0);
    check("rd_ta2_oe", 32'(ta2_oe), 32'd1);
    check("rd_ta2_zero", 32'(ta2_out), 32'd0);
    check("rd_data_oe", 32'(oe_low), 32'd0);
    check("rd_data", 32'(got), 32'hA5C3);
    check("rd_release", 32'(mdio_oe), 32'd0);
    check("rd_count", 32'(rd_cnt - rd0), 32'd1);
    check("rd_addr", 32'(addr), 32'h1F);
    check("rd_no_wr_err", 32'((wr_cnt - wr0) + (err_cnt - er0)), 32'd0);

    // Foreign PHY address, then an accepted write
    oe_seen = 1'b0;
    wr0 = wr_cnt; rd0 = rd_cnt; er0 = err_cnt;
    write_frame(32, 5'd2, 5'h0A, 16'h1111);
    check("phy2_no_strobe", 32'((wr_cnt - wr0) + (rd_cnt - rd0)), 32'd0);
    check("phy2_no_err", 32'(err_cnt - er0), 32'd0);
    check("phy2_no_oe", 32'(oe_seen), 32'd0);
    check("phy2_addr_held", 32'(addr), 32'h1F);
    write_frame(32, 5'd1, 5'h03, 16'h1234);
    check("phy1_after_count", 32'(wr_cnt - wr0), 32'd1);
    check("phy1_after_data", 32'(wr_data), 32'h1234);
    check("phy1_after_addr", 32'(addr), 32'h03);

    // Short preamble is ignored
    wr0 = wr_cnt; rd0 = rd_cnt; er0 = err_cnt;
    write_frame(31, 5'd1, 5'h07, 16'h5678);
    check("pre31_no_wr", 32'(wr_cnt - wr0), 32'd0);
    check("pre31_data_held", 32'(wr_data), 32'h1234);
    check("pre31_addr_held", 32'(addr), 32'h03);
    check("pre31_no_err", 32'(err_cnt - er0), 32'd0);

    // Illegal opcode 11
    wr0 = wr_cnt; rd0 = rd_cnt; er0 = err_cnt;
    preamble(32);
    mbit(1'b0); mbit(1'b1); mbit(1'b1); mbit(1'b1);
    preamble(10);
    check("op11_err", 32'(err_cnt - er0), 32'd1);
    check("op11_no_strobe", 32'((wr_cnt - wr0) + (rd_cnt - rd0)), 32'd0);

    // Reset in the middle of read data
    mem[12] = 16'hFFFF;
    wr0 = wr_cnt; rd0 = rd_cnt; er0 = err_cnt;
    read_frame(5'h0C, 8, ta1_oe, ta2_oe, ta2_out, oe_low, got);
    #20;
    check("midrd_oe_before", 32'(mdio_oe), 32'd1);
    check("midrd_bits", 32'(got[7:0]), 32'hFF);
    reset = 1'b0;
    #1;
    check("midrd_oe_reset", 32'(mdio_oe), 32'd0);
    check("midrd_out_reset", 32'(mdio_out), 32'd0);
    #50 reset = 1'b1;
    #100;
    check("midrd_strobes", 32'((wr_cnt - wr0) + (err_cnt - er0)), 32'd0);
    check("midrd_rd_once", 32'(rd_cnt - rd0), 32'd1);
    write_frame(32, 5'd1, 5'h09, 16'hCAFE);
    check("postrst_wr_count", 32'(wr_cnt - wr0), 32'd1);
    check("postrst_wr_data", 32'(wr_data), 32'hCAFE);
    check("postrst_addr", 32'(addr), 32'h09);

    // Back-to-back write then read of the same register
    write_frame(32, 5'd1, 5'h00, 16'h0001);
    check("b2b_wr_data", 32'(wr_data), 32'h0001);
    read_frame(5'h00, 16, ta1_oe, ta2_oe, ta2_out, oe_low, got);
    #100;
    check("b2b_rd_data", 32'(got), 32'h0001);
    check("b2b_rd_oe", 32'(oe_low), 32'd0);
    check("b2b_release", 32'(mdio_oe), 32'd0);

    check("never_both_strobes", 32'(both_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdio_responder.md
MDIO_RESPONDER -- requirements
Module: mdio_responder

Interface
REQ-001 Parameter PHY_ADDR, default 5'd1, is the PHY address this responder answers to.
REQ-002 Parameter PRE_MIN, default 32, is the minimum number of consecutive '1' bits accepted as preamble.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 mdc  input  1  management clock from the MDIO initiator; asynchronous to clk, slower than clk/4.
REQ-006 mdio_in  input  1  serial data line as seen by the responder.
REQ-007 mdio_out  output  1  serial data driven by the responder.
REQ-008 mdio_oe  output  1  '1' = responder drives the line with mdio_out.
REQ-009 addr  output  5  register address (REGAD) of the current or last frame.
REQ-010 wr_data  output  16  write data of the last accepted write frame.
REQ-011 wr_stb  output  1  one-clk pulse; addr and wr_data are valid.
REQ-012 rd_stb  output  1  one-clk pulse requesting the register at addr.
REQ-013 rd_data  input  16  register contents; valid on the clk after rd_stb.
REQ-014 frame_err  output  1  one-clk pulse on an aborted frame.

Function
REQ-015 mdc and mdio_in shall pass through 2-flop synchronizers; a bit event is a detected 0->1 edge of synchronized mdc, with mdio_in sampled in that same clk.
REQ-016 States: IDLE, START, OP, PHYAD, REGAD, TA, WDATA, RDATA; bits are MSB first; a counter tracks bit position within each field.
REQ-017 IDLE: count consecutive '1' bits, saturating at PRE_MIN; a '0' with count >= PRE_MIN -> START; a '0' with count < PRE_MIN clears the count.
REQ-018 START: bit '1' (ST = 01) -> OP; bit '0' -> frame_err, IDLE.
REQ-019 OP: 2 bits; 01 = write, 10 = read; 00/11 -> frame_err, IDLE.
REQ-020 PHYAD: 5 bits; mismatch with PHY_ADDR -> IDLE without frame_err, with no drive and no strobes.
REQ-021 REGAD: 5 bits shifted into addr; for a read, rd_stb pulses in the clk after the 5th bit event, then -> TA.
REQ-022 TA write: 2 bits ignored -> WDATA; TA read: mdio_oe = 0 for the first TA bit, then drive '0' from the clk after the first TA bit event.
REQ-023 Read data: rd_data captured into a 16-bit shift register in the clk after rd_stb; each bit is driven from the clk following the previous bit event, so the 16 bits follow TA bit 2 on successive mdc periods.
REQ-024 RDATA: after the 16th data bit event, release mdio_oe in the next clk -> IDLE, with the preamble count cleared.
REQ-025 WDATA: 16 bits shifted in; in the clk after the 16th bit event, update wr_data and pulse wr_stb for exactly one clk -> IDLE.
REQ-026 wr_stb and rd_stb are never asserted in the same clk, and each frame yields at most one strobe.
REQ-027 mdio_oe = 0 in every state except read TA bit 2 and RDATA.
REQ-028 addr and wr_data hold their values between frames.

Reset
REQ-029 On reset low, all outputs shall become 0 immediately and the FSM shall go to IDLE with the preamble count at 0; synchronizers reset to 0.
REQ-030 Reset asserted mid-frame shall abort the frame with no strobe and no frame_err; after release, a full preamble is required again.

Structure
REQ-031 Shared package mdio_pkg: state encoding, opcode constants (OP_WR = 2'b01, OP_RD = 2'b10), ST = 2'b01, field widths (5, 5, 16).
REQ-032 One sub-module, mdio_sync (2-flop synchronizer plus mdc rising-edge detect); everything else lives in mdio_responder.

Verification
REQ-033 Write with 32x'1' preamble, PHYAD = 1, REGAD = 0x05, data 0xBEEF -> one wr_stb, addr = 0x05, wr_data = 0xBEEF, mdio_oe = 0 throughout.
REQ-034 Read with PHYAD = 1, REGAD = 0x1F, rd_data = 0xA5C3 -> one rd_stb, addr = 0x1F; the line shows Z then 0 at TA, then 1010010111000011; mdio_oe drops after the last bit.
REQ-035 Write with PHYAD = 2 -> no strobe, no frame_err, mdio_oe = 0; an immediately following valid write to PHYAD = 1 is accepted.
REQ-036 Frame with only 31 preamble bits, then a valid write -> ignored; OP = 11 with a valid preamble -> frame_err pulse, no strobe.
REQ-037 Reset low during bit 8 of RDATA -> mdio_oe = 0 immediately, no strobes; a subsequent full write is accepted normally.
REQ-038 Back-to-back frames: a write 0x0001 to REGAD = 0x00, then a read of REGAD = 0x00 with rd_data looped from the written value -> 0x0001 shifted out.
